// File: rtl/frame_former.sv
// Byte-wide frame builder: fixed 16-byte header followed by Packet_Size
// payload bytes forwarded from the input stream, TLAST on the final byte.
module frame_former #(
  parameter int HDR_BYTES = 16,
  parameter int PS_WIDTH  = 14
) (
  input  logic                ACLK_0,
  input  logic                ARESET_0,
  input  logic [47:0]         Destination_Address_0,
  input  logic [47:0]         Source_Address_0,
  input  logic [15:0]         Link_Type_0,
  input  logic [15:0]         SyncWord_0,
  input  logic [PS_WIDTH-1:0] Packet_Size_0,
  input  logic [7:0]          S_AXIS_0_tdata,
  input  logic                S_AXIS_0_tvalid,
  output logic                S_AXIS_0_tready,
  input  logic                S_AXIS_0_tlast,
  output logic [7:0]          M_AXIS_0_tdata,
  output logic                M_AXIS_0_tvalid,
  input  logic                M_AXIS_0_tready,
  output logic                M_AXIS_0_tlast
);

  localparam int HW = HDR_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;

  state_t              state_q, state_d;
  logic [PS_WIDTH-1:0] cnt_q, cnt_d;
  logic [PS_WIDTH-1:0] ps_q, ps_d;
  logic [HW-1:0]       hdr_q, hdr_d;
  logic [7:0]          tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;

  logic                load_ok;
  logic                s_ready;
  logic [7:0]          hdr_byte;
  logic                hdr_last;
  logic                pay_last;
  logic                unused_tlast;

  // Frame length comes only from Packet_Size; input TLAST is ignored.
  assign unused_tlast = S_AXIS_0_tlast;

  assign load_ok  = !tvalid_q || M_AXIS_0_tready;
  assign hdr_last = (cnt_q[3:0] == 4'(HDR_BYTES - 1));
  assign pay_last = ((cnt_q + 1'b1) == ps_q);

  always_comb begin
    hdr_byte = '0;
    for (int i = 0; i < HDR_BYTES; i++) begin
      if (cnt_q[3:0] == 4'(i)) begin
        hdr_byte = hdr_q[HW-1-8*i -: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ps_d     = ps_q;
    hdr_d    = hdr_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    s_ready  = 1'b0;

    if (load_ok) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Header byte 0 comes from the live fields so it leaves next cycle.
        if (S_AXIS_0_tvalid && load_ok) begin
          hdr_d    = {Destination_Address_0, Source_Address_0,
                      Link_Type_0, SyncWord_0};
          ps_d     = Packet_Size_0;
          tdata_d  = Destination_Address_0[47:40];
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          cnt_d    = {{(PS_WIDTH-1){1'b0}}, 1'b1};
          state_d  = HEADER;
        end
      end
      HEADER: begin
        if (load_ok) begin
          tdata_d  = hdr_byte;
          tvalid_d = 1'b1;
          if (hdr_last) begin
            cnt_d = '0;
            if (ps_q == '0) begin
              tlast_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = PAYLOAD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PAYLOAD: begin
        s_ready = load_ok;
        if (load_ok && S_AXIS_0_tvalid) begin
          tdata_d  = S_AXIS_0_tdata;
          tvalid_d = 1'b1;
          if (pay_last) begin
            tlast_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK_0) begin
    if (ARESET_0) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ps_q     <= '0;
      hdr_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ps_q     <= ps_d;
      hdr_q    <= hdr_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign S_AXIS_0_tready = s_ready;
  assign M_AXIS_0_tdata  = tdata_q;
  assign M_AXIS_0_tvalid = tvalid_q;
  assign M_AXIS_0_tlast  = tlast_q;

endmodule

// File: tb/tb_frame_former.sv
// Randomized bench for frame_former: queue-based frame model checks every
// output handshake, input ordering, stall stability and reset behaviour.
module tb_frame_former;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] da_in, sa_in;
  logic [15:0] lt_in, sw_in;
  logic [13:0] ps_in;
  logic [7:0]  s_data;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  m_data;
  logic        m_valid, m_ready, m_last;

  always #5 clk = ~clk;

  frame_former dut (
    .ACLK_0                (clk),
    .ARESET_0              (rst),
    .Destination_Address_0 (da_in),
    .Source_Address_0      (sa_in),
    .Link_Type_0           (lt_in),
    .SyncWord_0            (sw_in),
    .Packet_Size_0         (ps_in),
    .S_AXIS_0_tdata        (s_data),
    .S_AXIS_0_tvalid       (s_valid),
    .S_AXIS_0_tready       (s_ready),
    .S_AXIS_0_tlast        (s_last),
    .M_AXIS_0_tdata        (m_data),
    .M_AXIS_0_tvalid       (m_valid),
    .M_AXIS_0_tready       (m_ready),
    .M_AXIS_0_tlast        (m_last)
  );

  typedef struct {
    logic [7:0] data;
    int         pos;
  } src_t;

  src_t       src_q[$];
  logic [8:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int n_out, n_exp, n_in, n_in_extra, n_rdy;
  int snk_mode, src_gap, gap_cnt, pat;
  bit rst_req, force_v;
  bit prev_stall;
  logic [7:0] prev_data;
  logic prev_last;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [47:0] da, input logic [47:0] sa,
                            input logic [15:0] lt, input logic [15:0] sw,
                            input int ps, input bit rnd);
    logic [127:0] hdr;
    src_t s;
    hdr = {da, sa, lt, sw};
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({(ps == 0 && i == 15), hdr[127-8*i -: 8]});
      n_exp++;
    end
    for (int i = 0; i < ps; i++) begin
      s.data = rnd ? 8'($urandom()) : 8'(i);
      s.pos  = n_exp;
      src_q.push_back(s);
      exp_q.push_back({(i == ps - 1), s.data});
      n_exp++;
    end
  endtask

  task automatic step();
    src_t e;
    logic [8:0] x;
    @(negedge clk);
    rst = rst_req;
    unique case (snk_mode)
      0: m_ready = 1'b1;
      1: m_ready = ((pat % 6) >= 4);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    pat++;
    if (gap_cnt > 0) begin
      gap_cnt--;
      s_valid = force_v;
    end else begin
      s_valid = (src_q.size() > 0) || force_v;
    end
    s_data = (src_q.size() > 0) ? src_q[0].data : 8'h5a;
    s_last = 1'($urandom_range(0, 1));
    #1;
    if (rst_req) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
        chk("hold_last", m_last, prev_last);
      end
      if (s_ready) n_rdy++;
      if (s_valid && s_ready) begin
        if (src_q.size() > 0) begin
          e = src_q.pop_front();
          chk("in_pos", n_out + int'(m_valid), e.pos);
        end else begin
          n_in_extra++;
        end
        n_in++;
        gap_cnt = src_gap;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() > 0) begin
          x = exp_q.pop_front();
          chk("tdata", m_data, x[7:0]);
          chk("tlast", m_last, x[8]);
        end
        n_out++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (exp_q.size() + src_q.size()) > 0; i++) step();
    chk("drain_left", exp_q.size() + src_q.size(), 0);
    repeat (8) step();
    chk("out_count", n_out, n_exp);
    chk("in_extra", n_in_extra, 0);
  endtask

  task automatic set_default_fields();
    da_in = 48'hb00b5cafecaf;
    sa_in = 48'hf00f00cafe12;
    lt_in = 16'h1337;
    sw_in = 16'hdead;
    ps_in = 14'd16;
  endtask

  initial begin
    set_default_fields();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    n_out = 0; n_exp = 0; n_in = 0; n_in_extra = 0; n_rdy = 0;
    snk_mode = 0; src_gap = 0; gap_cnt = 0; pat = 0;
    rst_req = 1'b1; force_v = 1'b0; prev_stall = 1'b0;
    repeat (3) step();
    rst_req = 1'b0;
    step();
    chk("rst_tvalid", m_valid, 0);
    chk("rst_tdata", m_data, 0);
    chk("rst_tlast", m_last, 0);
    chk("rst_tready", s_ready, 0);

    // Basic frame, counting payload, sink always ready.
    push_frame(da_in, sa_in, lt_in, sw_in, 16, 0);
    drain(200);

    // 21 back-to-back frames with sink 4 low / 2 high.
    snk_mode = 1;
    for (int f = 0; f < 21; f++) push_frame(da_in, sa_in, lt_in, sw_in, 16, 1);
    drain(5000);

    // Source gaps of two cycles between payload bytes.
    snk_mode = 0; src_gap = 2;
    for (int f = 0; f < 2; f++) push_frame(da_in, sa_in, lt_in, sw_in, 16, 1);
    drain(1000);
    src_gap = 0;

    // Header-only frame started by a single-cycle valid pulse.
    ps_in = 14'd0; n_rdy = 0;
    push_frame(da_in, sa_in, lt_in, sw_in, 0, 0);
    force_v = 1'b1;
    step();
    force_v = 1'b0;
    drain(200);
    chk("ps0_tready", n_rdy, 0);

    // Fields change during payload only affect the following frame.
    set_default_fields();
    push_frame(da_in, sa_in, lt_in, sw_in, 16, 1);
    push_frame(48'h0, sa_in, lt_in, sw_in, 4, 1);
    for (int i = 0; i < 200 && n_out < n_exp - 24; i++) step();
    chk("mid_reached", (n_out >= n_exp - 24), 1);
    da_in = 48'h0; ps_in = 14'd4;
    drain(300);

    // Randomized batches: random fields, sizes, sink and source gaps.
    for (int b = 0; b < 6; b++) begin
      da_in = 48'({$urandom(), $urandom()});
      sa_in = 48'({$urandom(), $urandom()});
      lt_in = 16'($urandom()); sw_in = 16'($urandom());
      ps_in = (b == 0) ? 14'd1 : 14'($urandom_range(1, 40));
      snk_mode = 2; src_gap = $urandom_range(0, 2);
      for (int f = 0; f < 4; f++)
        push_frame(da_in, sa_in, lt_in, sw_in, int'(ps_in), 1);
      drain(3000);
    end
    snk_mode = 0; src_gap = 0;

    // Maximum payload length, no counter wrap.
    ps_in = 14'd16383;
    push_frame(da_in, sa_in, lt_in, sw_in, 16383, 1);
    drain(17000);

    // Reset in the middle of payload abandons the frame.
    set_default_fields();
    n_in = 0;
    push_frame(da_in, sa_in, lt_in, sw_in, 16, 1);
    for (int i = 0; i < 200 && n_in < 5; i++) step();
    chk("rst_mid_reached", n_in, 5);
    src_q.delete();
    exp_q.delete();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk("mid_rst_tvalid", m_valid, 0);
    chk("mid_rst_tdata", m_data, 0);
    chk("mid_rst_tlast", m_last, 0);
    chk("mid_rst_tready", s_ready, 0);
    n_out = 0; n_exp = 0; n_in_extra = 0;
    push_frame(da_in, sa_in, lt_in, sw_in, 16, 1);
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
